mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
- Parametrised MEM/WB pipeline register for the 5-stage MIPS core. Registers the MEM-stage write-back bundle toward the WB stage and the regfile.
- Bundle contents: GPR write, optional HI/LO write, LLbit write, and a valid flag.
- Adds stall hold and bubble insertion driven by the central stall controller, plus an exception flush.
- Keeps a saturating bubble/flush event counter for performance debug.

Parameters:
- DATA_W, 32, width of GPR, HI and LO data.
- ADDR_W, 5, regfile address width.
- HILO_EN, 1, 1 = HI/LO path registered; 0 = HI/LO outputs constant zero.
- CNT_W, 16, width of the bubble/flush event counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- stall_mem  in  1  MEM stage stalled this cycle.
- stall_wb  in  1  WB stage stalled this cycle.
- flush  in  1  exception flush; kills the in-flight MEM instruction.
- mem_valid  in  1  MEM bundle holds a real instruction.
- mem_wd  in  ADDR_W  destination GPR address.
- mem_wreg  in  1  GPR write enable.
- mem_wdata  in  DATA_W  GPR write data.
- mem_whilo  in  1  HI/LO write enable.
- mem_hi  in  DATA_W  HI write data.
- mem_lo  in  DATA_W  LO write data.
- mem_llbit_we  in  1  LLbit write enable.
- mem_llbit_value  in  1  LLbit write value.
- wb_valid  out  1  registered valid.
- wb_wd  out  ADDR_W  registered destination address.
- wb_wreg  out  1  registered GPR write enable.
- wb_wdata  out  DATA_W  registered GPR data.
- wb_whilo  out  1  registered HI/LO write enable.
- wb_hi  out  DATA_W  registered HI data.
- wb_lo  out  DATA_W  registered LO data.
- wb_llbit_we  out  1  registered LLbit write enable.
- wb_llbit_value  out  1  registered LLbit value.
- bubble_cnt  out  CNT_W  saturating count of bubble and flush events.

Behaviour:
- All outputs are registered on posedge clk; latency is 1 cycle from MEM inputs to wb_* outputs. There is no combinational path from inputs to outputs.
- Reset: when rst=1 at a posedge, every wb_* output and bubble_cnt become 0. Reset overrides everything, including mid-stall and mid-flush.
- Bundle update priority per cycle, highest first:
  1. rst -> clear all outputs.
  2. flush=1 -> load bubble (all wb_* = 0), regardless of stall inputs.
  3. stall_mem=1 and stall_wb=0 -> load bubble. MEM is frozen but WB proceeds, so the same instruction must not retire twice.
  4. stall_wb=1 -> hold all wb_* unchanged, whichever value stall_mem has.
  5. Otherwise -> load the MEM bundle.
- Load qualification:
  - Every write enable is ANDed with mem_valid when loaded: wb_wreg = mem_wreg & mem_valid, and likewise for whilo and llbit_we. Data fields load unmodified.
  - wb_valid = mem_valid.
- Bubble definition: valid=0, all write enables 0, all data and address fields 0.
- HILO_EN=0: wb_whilo, wb_hi and wb_lo are constant 0 in every cycle; mem_whilo, mem_hi and mem_lo are ignored.
- bubble_cnt:
  - Increments by 1 on each cycle in which priority case 2 or 3 fires and the register is not held. Hold cycles do not count.
  - Saturates at 2^CNT_W-1 and never wraps.
  - Cleared only by rst.
- Stall inputs are level-sensitive. Multi-cycle stall_wb holds indefinitely. Release loads the MEM bundle present in the release cycle.

Test Plan:
- Reset and pass-through: assert rst for 2 cycles, then drive mem_valid=1, mem_wd=5'd3, mem_wreg=1, mem_wdata=32'hDEADBEEF -> all outputs 0 during reset; next cycle wb_wd=3, wb_wreg=1, wb_wdata=DEADBEEF, wb_valid=1, bubble_cnt=0.
- Bubble insertion: load wd=7 / wdata=0x11, then stall_mem=1, stall_wb=0 for 3 cycles -> wb bundle all zero and wb_valid=0 for 3 cycles, bubble_cnt=3; after release, the next MEM bundle appears 1 cycle later.
- Hold: load wdata=0x22 with whilo=1, hi=0xAA, lo=0xBB, then stall_mem=1, stall_wb=1 for 4 cycles -> all wb_* stay 0x22 / 0xAA / 0xBB / whilo=1, bubble_cnt unchanged.
- Flush priority: flush=1 together with stall_wb=1 while wb holds a valid write -> next cycle bubble, bubble_cnt+1; mem_valid=0 with mem_wreg=1 -> wb_wreg=0.
- Saturation and gating: CNT_W=2, issue 6 consecutive flushes -> bubble_cnt goes 1, 2, 3, 3, 3, 3; assert rst mid-sequence -> bubble_cnt=0 on the next cycle.
- HILO_EN=0 build: drive mem_whilo=1, mem_hi=0x5, mem_lo=0x6 -> wb_whilo=0, wb_hi=0, wb_lo=0 in all cycles; LLbit we=1 / value=1 passes through to wb_llbit_* after 1 cycle.

Source files
------------

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: carries the MEM-stage write-back bundle to WB,
// with stall hold, bubble insertion, exception flush and a bubble counter.
module mem_wb_stage #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned HILO_EN = 1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_mem,
  input  logic              stall_wb,
  input  logic              flush,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_wd,
  input  logic              mem_wreg,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_whilo,
  input  logic [DATA_W-1:0] mem_hi,
  input  logic [DATA_W-1:0] mem_lo,
  input  logic              mem_llbit_we,
  input  logic              mem_llbit_value,
  output logic              wb_valid,
  output logic [ADDR_W-1:0] wb_wd,
  output logic              wb_wreg,
  output logic [DATA_W-1:0] wb_wdata,
  output logic              wb_whilo,
  output logic [DATA_W-1:0] wb_hi,
  output logic [DATA_W-1:0] wb_lo,
  output logic              wb_llbit_we,
  output logic              wb_llbit_value,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic load_bubble;
  logic hold;

  // Flush beats every stall; a frozen MEM with a running WB must not retire twice.
  always_comb begin
    load_bubble = flush | (stall_mem & ~stall_wb);
    hold        = stall_wb & ~flush;
  end

  // GPR / LLbit / valid part of the bundle.
  always_ff @(posedge clk) begin
    if (rst || load_bubble) begin
      wb_valid       <= 1'b0;
      wb_wd          <= '0;
      wb_wreg        <= 1'b0;
      wb_wdata       <= '0;
      wb_llbit_we    <= 1'b0;
      wb_llbit_value <= 1'b0;
    end else if (!hold) begin
      wb_valid       <= mem_valid;
      wb_wd          <= mem_wd;
      wb_wreg        <= mem_wreg & mem_valid;
      wb_wdata       <= mem_wdata;
      wb_llbit_we    <= mem_llbit_we & mem_valid;
      wb_llbit_value <= mem_llbit_value;
    end
  end

  // Saturating bubble/flush event counter; held cycles are not counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt <= '0;
    end else if (load_bubble && (bubble_cnt != CNT_MAX)) begin
      bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

  generate
    if (HILO_EN != 0) begin : g_hilo
      // HI/LO part of the bundle, same update rules as the GPR part.
      always_ff @(posedge clk) begin
        if (rst || load_bubble) begin
          wb_whilo <= 1'b0;
          wb_hi    <= '0;
          wb_lo    <= '0;
        end else if (!hold) begin
          wb_whilo <= mem_whilo & mem_valid;
          wb_hi    <= mem_hi;
          wb_lo    <= mem_lo;
        end
      end
    end else begin : g_no_hilo
      logic unused_hilo;
      assign unused_hilo = ^{mem_whilo, mem_hi, mem_lo};
      assign wb_whilo    = 1'b0;
      assign wb_hi       = '0;
      assign wb_lo       = '0;
    end
  endgenerate

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: dut_a (HI/LO on, 2-bit counter) and
// dut_b (HI/LO off, 16-bit counter) share one stimulus stream.
module tb_mem_wb_stage;

  typedef struct packed {
    logic        valid;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic        whilo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        llwe;
    logic        llv;
  } bnd_t;

  typedef struct packed {
    bnd_t        b;
    logic [1:0]  ca;
    logic [15:0] cb;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stall_mem = 1'b0, stall_wb = 1'b0, flush = 1'b0;
  logic mem_valid = 1'b0, mem_wreg = 1'b0, mem_whilo = 1'b0;
  logic mem_llbit_we = 1'b0, mem_llbit_value = 1'b0;
  logic [4:0]  mem_wd = '0;
  logic [31:0] mem_wdata = '0, mem_hi = '0, mem_lo = '0;

  logic        a_valid, a_wreg, a_whilo, a_llwe, a_llv;
  logic [4:0]  a_wd;
  logic [31:0] a_wdata, a_hi, a_lo;
  logic [1:0]  a_cnt;
  logic        b_valid, b_wreg, b_whilo, b_llwe, b_llv;
  logic [4:0]  b_wd;
  logic [31:0] b_wdata, b_hi, b_lo;
  logic [15:0] b_cnt;

  int compared = 0;
  int mismatched = 0;
  exp_t q[$];

  bnd_t m = '0;
  logic [1:0]  mca = '0;
  logic [15:0] mcb = '0;

  always #5 clk = ~clk;

  mem_wb_stage #(.DATA_W(32), .ADDR_W(5), .HILO_EN(1), .CNT_W(2)) dut_a (
    .clk(clk), .rst(rst), .stall_mem(stall_mem), .stall_wb(stall_wb), .flush(flush),
    .mem_valid(mem_valid), .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
    .mem_llbit_we(mem_llbit_we), .mem_llbit_value(mem_llbit_value),
    .wb_valid(a_valid), .wb_wd(a_wd), .wb_wreg(a_wreg), .wb_wdata(a_wdata),
    .wb_whilo(a_whilo), .wb_hi(a_hi), .wb_lo(a_lo),
    .wb_llbit_we(a_llwe), .wb_llbit_value(a_llv), .bubble_cnt(a_cnt)
  );

  mem_wb_stage #(.DATA_W(32), .ADDR_W(5), .HILO_EN(0), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst), .stall_mem(stall_mem), .stall_wb(stall_wb), .flush(flush),
    .mem_valid(mem_valid), .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
    .mem_llbit_we(mem_llbit_we), .mem_llbit_value(mem_llbit_value),
    .wb_valid(b_valid), .wb_wd(b_wd), .wb_wreg(b_wreg), .wb_wdata(b_wdata),
    .wb_whilo(b_whilo), .wb_hi(b_hi), .wb_lo(b_lo),
    .wb_llbit_we(b_llwe), .wb_llbit_value(b_llv), .bubble_cnt(b_cnt)
  );

  function automatic bnd_t mk(input logic v, input logic [4:0] wd, input logic wreg,
                              input logic [31:0] wdata, input logic whilo,
                              input logic [31:0] hi, input logic [31:0] lo,
                              input logic llwe, input logic llv);
    bnd_t r;
    r = '{valid: v, wd: wd, wreg: wreg, wdata: wdata, whilo: whilo,
          hi: hi, lo: lo, llwe: llwe, llv: llv};
    return r;
  endfunction

  // Drive one cycle of stimulus and queue the response expected after the next edge.
  task automatic cyc(input logic r, input logic sm, input logic sw, input logic fl,
                     input bnd_t b);
    exp_t e;
    @(negedge clk);
    rst = r; stall_mem = sm; stall_wb = sw; flush = fl;
    mem_valid = b.valid; mem_wd = b.wd; mem_wreg = b.wreg; mem_wdata = b.wdata;
    mem_whilo = b.whilo; mem_hi = b.hi; mem_lo = b.lo;
    mem_llbit_we = b.llwe; mem_llbit_value = b.llv;
    if (r) begin
      m = '0; mca = '0; mcb = '0;
    end else if (fl || (sm && !sw)) begin
      m = '0;
      if (mca != 2'd3) mca = mca + 2'd1;
      if (mcb != 16'hFFFF) mcb = mcb + 16'd1;
    end else if (!sw) begin
      m = b;
      m.wreg  = b.wreg & b.valid;
      m.whilo = b.whilo & b.valid;
      m.llwe  = b.llwe & b.valid;
    end
    e.b = m; e.ca = mca; e.cb = mcb;
    q.push_back(e);
  endtask

  // Monitor: every edge with an outstanding expectation is compared for both builds.
  always @(posedge clk) begin
    exp_t e;
    bnd_t act_a, act_b, exp_b;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      act_a = {a_valid, a_wd, a_wreg, a_wdata, a_whilo, a_hi, a_lo, a_llwe, a_llv};
      act_b = {b_valid, b_wd, b_wreg, b_wdata, b_whilo, b_hi, b_lo, b_llwe, b_llv};
      exp_b = e.b;
      exp_b.whilo = 1'b0; exp_b.hi = '0; exp_b.lo = '0;
      compared++;
      if (act_a !== e.b || a_cnt !== e.ca) begin
        mismatched++;
        $display("FAIL dut_a @%0t bundle got %h want %h cnt got %0d want %0d",
                 $time, act_a, e.b, a_cnt, e.ca);
      end
      compared++;
      if (act_b !== exp_b || b_cnt !== e.cb) begin
        mismatched++;
        $display("FAIL dut_b @%0t bundle got %h want %h cnt got %0d want %0d",
                 $time, act_b, exp_b, b_cnt, e.cb);
      end
    end
  end

  initial begin
    bnd_t z;
    z = '0;
    // reset with a live bundle on the inputs, then pass-through
    cyc(1, 0, 0, 0, mk(1, 5'd3, 1, 32'hDEADBEEF, 0, 0, 0, 0, 0));
    cyc(1, 0, 0, 0, mk(1, 5'd3, 1, 32'hDEADBEEF, 0, 0, 0, 0, 0));
    cyc(0, 0, 0, 0, mk(1, 5'd3, 1, 32'hDEADBEEF, 0, 0, 0, 0, 0));
    // bubble insertion: MEM frozen, WB running
    cyc(0, 0, 0, 0, mk(1, 5'd7, 1, 32'h11, 0, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, mk(1, 5'd7, 1, 32'h11, 0, 0, 0, 0, 0));
    cyc(0, 0, 0, 0, mk(1, 5'd9, 1, 32'h33, 0, 0, 0, 0, 0));
    // hold: both stalls, changing inputs must not leak through
    cyc(0, 0, 0, 0, mk(1, 5'd4, 1, 32'h22, 1, 32'hAA, 32'hBB, 0, 0));
    for (int i = 0; i < 4; i++)
      cyc(0, 1, 1, 0, mk(1, 5'(i), 0, 32'h100 + 32'(i), 0, 32'h1, 32'h2, 1, 1));
    // hold by stall_wb alone
    cyc(0, 0, 1, 0, mk(1, 5'd1, 1, 32'h55, 0, 0, 0, 0, 0));
    // flush wins over stall_wb while a valid write is held
    cyc(0, 0, 1, 1, mk(1, 5'd2, 1, 32'h66, 1, 32'h7, 32'h8, 1, 1));
    // invalid instruction: enables gated, data fields still load
    cyc(0, 0, 0, 0, mk(0, 5'd12, 1, 32'h77, 1, 32'hC, 32'hD, 1, 1));
    // flush together with stall_mem counts once
    cyc(0, 1, 0, 1, mk(1, 5'd13, 1, 32'h88, 0, 0, 0, 0, 0));
    // saturation: reset then 6 flushes
    cyc(1, 0, 0, 0, z);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1, mk(1, 5'd5, 1, 32'h99, 0, 0, 0, 0, 0));
    // reset in the middle of a flush run
    cyc(0, 0, 0, 1, z);
    cyc(1, 0, 1, 1, mk(1, 5'd5, 1, 32'h99, 1, 32'h1, 32'h1, 1, 1));
    cyc(0, 0, 0, 1, z);
    // HI/LO and LLbit pass-through, then a hold and a release
    cyc(0, 0, 0, 0, mk(1, 5'd6, 0, 32'h0, 1, 32'h5, 32'h6, 1, 1));
    cyc(0, 0, 1, 0, mk(1, 5'd8, 1, 32'hAB, 1, 32'h9, 32'hA, 0, 0));
    cyc(0, 0, 0, 0, mk(1, 5'd31, 1, 32'hFFFFFFFF, 1, 32'hFFFFFFFF, 32'h12345678, 1, 0));
    cyc(0, 0, 0, 0, z);

    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    #2;
    compared++;
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL drain pending got %0d want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
